// File: rtl/mem_responder.sv
// Memory-side responder for the MAR/MDR interface: wait-stated single-port word array with done/err pulses.
// Optional write protection of addresses >= WP_BASE is enabled by defining MEM_WP_EN.
module mem_responder #(
  parameter int ADDR_W      = 9,
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 512,
  parameter int WAIT_CYCLES = 1,
  parameter int WP_BASE     = 448
) (
  input  logic              clk,
  input  logic              clr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              read,
  input  logic              write,
  output logic [DATA_W-1:0] rdata,
  output logic              done,
  output logic              busy,
  output logic              err
);

`ifdef MEM_WP_EN
  localparam bit WP_ON = 1'b1;
`else
  localparam bit WP_ON = 1'b0;
`endif

  localparam logic [3:0]        CNT_INIT = 4'(WAIT_CYCLES);
  localparam logic [ADDR_W-1:0] WP_ADDR  = ADDR_W'(WP_BASE);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_ACCESS = 2'd2
  } state_t;

  state_t              state_q;
  logic [3:0]          cnt_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                wr_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                done_q;
  logic                busy_q;
  logic                err_q;
  logic                wp_hit;
  logic                mem_we;

  logic [DATA_W-1:0]   mem_q [DEPTH];

  assign wp_hit = WP_ON && (addr_q >= WP_ADDR);
  // clr must also block the array write so an aborted access never commits.
  assign mem_we = !clr && (state_q == S_ACCESS) && wr_q && !wp_hit;

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[addr_q] <= wdata_q;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          busy_q <= 1'b0;
          if (read ^ write) begin
            addr_q  <= addr;
            wdata_q <= wdata;
            wr_q    <= write;
            cnt_q   <= CNT_INIT;
            busy_q  <= 1'b1;
            state_q <= (WAIT_CYCLES > 0) ? S_WAIT : S_ACCESS;
          end else if (read && write) begin
            err_q <= 1'b1;
          end
        end
        S_WAIT: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_q <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          // busy_q stays high through the done cycle; IDLE clears it afterwards.
          done_q <= 1'b1;
          if (!wr_q) begin
            rdata_q <= mem_q[addr_q];
          end else if (wp_hit) begin
            err_q <= 1'b1;
          end
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign rdata = rdata_q;
  assign done  = done_q;
  assign busy  = busy_q;
  assign err   = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: two instances (WAIT_CYCLES=0 and 1), expected events queued
// by the stimulus and popped by a negedge monitor whenever done or err is seen.
module tb_mem_responder;
  localparam int AW = 9;
  localparam int DW = 32;

  typedef struct {
    int          cyc;
    logic        done;
    logic        err;
    logic [31:0] rdata;
    bit          ne;
    logic [31:0] ne_val;
  } ev_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [1:0]    clr_s, rd_s, wr_s, done_s, busy_s, err_s;
  logic [AW-1:0] addr_s  [2];
  logic [DW-1:0] wdata_s [2];
  logic [DW-1:0] rdata_s [2];

  mem_responder #(.WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .clr(clr_s[0]), .addr(addr_s[0]), .wdata(wdata_s[0]),
    .read(rd_s[0]), .write(wr_s[0]), .rdata(rdata_s[0]),
    .done(done_s[0]), .busy(busy_s[0]), .err(err_s[0])
  );

  mem_responder #(.WAIT_CYCLES(1)) u_dut1 (
    .clk(clk), .clr(clr_s[1]), .addr(addr_s[1]), .wdata(wdata_s[1]),
    .read(rd_s[1]), .write(wr_s[1]), .rdata(rdata_s[1]),
    .done(done_s[1]), .busy(busy_s[1]), .err(err_s[1])
  );

  ev_t         q0[$];
  ev_t         q1[$];
  int          checks = 0;
  int          passed = 0;
  logic [31:0] mm  [2][512];
  logic [31:0] rdm [2];

  function automatic int wc(input int d);
    return (d == 0) ? 0 : 1;
  endfunction

  function automatic int qsize(input int d);
    return (d == 0) ? q0.size() : q1.size();
  endfunction

  task automatic push(input int d, input ev_t e);
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%h, required 0x%h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mon_event(input int d);
    ev_t e;
    if (qsize(d) == 0) begin
      checks++;
      $display("FAIL dut%0d unexpected_event: done=%b err=%b at cycle %0d, required no event",
               d, done_s[d], err_s[d], cyc);
      return;
    end
    e = (d == 0) ? q0.pop_front() : q1.pop_front();
    chk($sformatf("dut%0d event_cycle", d), 32'(cyc), 32'(e.cyc));
    chk($sformatf("dut%0d done", d), 32'(done_s[d]), 32'(e.done));
    chk($sformatf("dut%0d err", d), 32'(err_s[d]), 32'(e.err));
    if (e.ne) begin
      checks++;
      if (rdata_s[d] !== e.ne_val) passed++;
      else $display("FAIL dut%0d protected_read: got 0x%h, required anything else", d, rdata_s[d]);
    end else begin
      chk($sformatf("dut%0d rdata", d), rdata_s[d], e.rdata);
    end
    $display("dut%0d event cycle=%0d done=%b err=%b rdata=0x%h", d, cyc, done_s[d], err_s[d], rdata_s[d]);
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (done_s[d] || err_s[d]) mon_event(d);
    end
  end

  task automatic wait_drain(input int d);
    int n;
    n = 0;
    while (qsize(d) != 0 && n < 20) begin
      step();
      n++;
    end
    if (qsize(d) != 0) begin
      checks++;
      $display("FAIL dut%0d timeout: %0d events outstanding, required 0", d, qsize(d));
      if (d == 0) q0.delete();
      else        q1.delete();
    end
    step();
    step();
  endtask

  // Drive one access in the cycle after a posedge; accepted at the next edge.
  task automatic issue(input int d, input bit wr, input logic [8:0] a, input logic [31:0] wd);
    ev_t e;
    bit  blocked;
    blocked = 1'b0;
`ifdef MEM_WP_EN
    blocked = wr && (a >= 9'd448);
`endif
    addr_s[d]  = a;
    wdata_s[d] = wd;
    rd_s[d]    = !wr;
    wr_s[d]    = wr;
    e.cyc    = cyc + wc(d) + 2;
    e.done   = 1'b1;
    e.err    = blocked;
    e.ne     = 1'b0;
    e.ne_val = '0;
    if (wr) begin
      if (!blocked) mm[d][a] = wd;
    end else begin
`ifdef MEM_WP_EN
      if (a >= 9'd448) begin
        e.ne     = 1'b1;
        e.ne_val = 32'hA5A5_A5A5;
      end
`endif
      rdm[d] = mm[d][a];
    end
    e.rdata = rdm[d];
    push(d, e);
    step();
    rd_s[d] = 1'b0;
    wr_s[d] = 1'b0;
    chk($sformatf("dut%0d busy_after_accept", d), 32'(busy_s[d]), 32'd1);
    wait_drain(d);
  endtask

  task automatic check_reset_outputs(input int d);
    chk($sformatf("dut%0d reset_rdata", d), rdata_s[d], 32'd0);
    chk($sformatf("dut%0d reset_done", d), 32'(done_s[d]), 32'd0);
    chk($sformatf("dut%0d reset_busy", d), 32'(busy_s[d]), 32'd0);
    chk($sformatf("dut%0d reset_err", d), 32'(err_s[d]), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    ev_t e;
    int  k;
    clr_s = 2'b11;
    rd_s  = 2'b00;
    wr_s  = 2'b00;
    for (int d = 0; d < 2; d++) begin
      addr_s[d]  = '0;
      wdata_s[d] = '0;
      rdm[d]     = '0;
    end
    step();
    step();
    clr_s = 2'b00;
    check_reset_outputs(0);
    check_reset_outputs(1);

    // Reset keeps array contents
    issue(1, 1'b1, 9'h005, 32'hDEAD_BEEF);
    issue(1, 1'b0, 9'h005, 32'h0);
    clr_s[1] = 1'b1;
    step();
    clr_s[1] = 1'b0;
    rdm[1] = '0;
    check_reset_outputs(1);
    issue(1, 1'b0, 9'h005, 32'h0);

    // Write then read with one wait state
    issue(1, 1'b1, 9'h010, 32'h1234_5678);
    issue(1, 1'b0, 9'h010, 32'h0);
    issue(1, 1'b1, 9'h011, 32'h0BAD_CAFE);

    // Read+write conflict: single err pulse, no access
    addr_s[1] = 9'h010; wdata_s[1] = 32'h5555_5555;
    rd_s[1] = 1'b1; wr_s[1] = 1'b1;
    e.cyc = cyc + 1; e.done = 1'b0; e.err = 1'b1; e.rdata = rdm[1]; e.ne = 1'b0; e.ne_val = '0;
    push(1, e);
    step();
    rd_s[1] = 1'b0; wr_s[1] = 1'b0;
    chk("dut1 conflict_busy", 32'(busy_s[1]), 32'd0);
    wait_drain(1);
    issue(1, 1'b0, 9'h010, 32'h0);

    // clr during WAIT aborts a write
    issue(1, 1'b1, 9'h1FF, 32'h0BAD_F00D);
    addr_s[1] = 9'h1FF; wdata_s[1] = 32'hFFFF_FFFF; wr_s[1] = 1'b1;
    step();
    wr_s[1] = 1'b0;
    clr_s[1] = 1'b1;
    step();
    clr_s[1] = 1'b0;
    rdm[1] = '0;
    chk("dut1 abort_busy", 32'(busy_s[1]), 32'd0);
    chk("dut1 abort_rdata", rdata_s[1], 32'd0);
    step(); step(); step();
    issue(1, 1'b0, 9'h1FF, 32'h0);

    // Held read, zero wait states: done every second cycle
    issue(0, 1'b1, 9'h000, 32'h0000_0100);
    issue(0, 1'b1, 9'h001, 32'h0000_0201);
    issue(0, 1'b1, 9'h002, 32'h0000_0302);
    k = cyc;
    rd_s[0] = 1'b1; addr_s[0] = 9'h000;
    for (int i = 0; i < 3; i++) begin
      e.cyc = k + 2 + 2 * i; e.done = 1'b1; e.err = 1'b0; e.rdata = mm[0][i];
      e.ne = 1'b0; e.ne_val = '0;
      push(0, e);
    end
    rdm[0] = mm[0][2];
    step();
    addr_s[0] = 9'h001;
    step();
    step();
    addr_s[0] = 9'h002;
    step();
    step();
    rd_s[0] = 1'b0;
    wait_drain(0);

    // Write to the protected region (or plain write without protection)
    issue(1, 1'b1, 9'd448, 32'hA5A5_A5A5);
    issue(1, 1'b0, 9'd448, 32'h0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
